// File: rtl/dtcm_arbiter_pkg.sv
// Shared types and helpers for the DTCM two-master arbiter.
// Master IDs are 1 bit wide: the LSU is ID_M0 and the secondary master is ID_M1.
package dtcm_arbiter_pkg;

    localparam int ID_W = 1;

    typedef enum logic [ID_W-1:0] {
        ID_M0 = 1'b0,
        ID_M1 = 1'b1
    } mid_e;

    // Round-robin pick: on a tie the master that did not win last time is chosen.
    function automatic mid_e rr_pick(input logic v0, input logic v1, input mid_e last);
        mid_e pick;
        if (v0 && v1) begin
            pick = (last == ID_M0) ? ID_M1 : ID_M0;
        end else if (v1) begin
            pick = ID_M1;
        end else begin
            pick = ID_M0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/dtcm_arbiter_id_fifo.sv
// In-order owner-ID FIFO. Each entry records which master issued an accepted command.
// A push into a full FIFO is dropped even when a pop happens in the same cycle.
module dtcm_arbiter_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ptr_next(r_wptr);
            end
            if (w_pop_ok) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dtcm_arbiter.sv
// Two-master round-robin arbiter in front of the single DTCM controller port.
// Commands are granted combinationally; responses return in order to the recorded owner.
module dtcm_arbiter
    import dtcm_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MW         = 4,
    parameter int OUTS_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic          m0_cmd_read,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [MW-1:0] m0_cmd_wmask,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic [DW-1:0] m0_rsp_rdata,
    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic          m1_cmd_read,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [MW-1:0] m1_cmd_wmask,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          s_cmd_valid,
    input  logic          s_cmd_ready,
    output logic          s_cmd_read,
    output logic [AW-1:0] s_cmd_addr,
    output logic [DW-1:0] s_cmd_wdata,
    output logic [MW-1:0] s_cmd_wmask,
    input  logic          s_rsp_valid,
    output logic          s_rsp_ready,
    input  logic [DW-1:0] s_rsp_rdata,
    output logic          arb_err
);

    mid_e  r_last_grant;
    logic  r_lock;
    mid_e  r_lock_id;
    logic  r_arb_err;

    mid_e  w_gnt;
    logic  w_gnt_valid;
    logic  w_cmd_hs;
    logic  w_fifo_full;
    logic  w_fifo_empty;
    logic  w_fifo_dout;
    mid_e  w_head;
    logic  w_pop;

    // Grant: a stalled command keeps its master until it handshakes.
    always_comb begin
        w_gnt = ID_M0;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else begin
            w_gnt = rr_pick(m0_cmd_valid, m1_cmd_valid, r_last_grant);
        end
    end

    assign w_gnt_valid  = (w_gnt == ID_M1) ? m1_cmd_valid : m0_cmd_valid;
    assign s_cmd_valid  = w_gnt_valid & ~w_fifo_full;
    assign w_cmd_hs     = s_cmd_valid & s_cmd_ready;
    assign m0_cmd_ready = (w_gnt == ID_M0) & m0_cmd_valid & s_cmd_ready & ~w_fifo_full;
    assign m1_cmd_ready = (w_gnt == ID_M1) & m1_cmd_valid & s_cmd_ready & ~w_fifo_full;

    // Command field mux; m0 fields pass through while idle.
    always_comb begin
        s_cmd_read  = m0_cmd_read;
        s_cmd_addr  = m0_cmd_addr;
        s_cmd_wdata = m0_cmd_wdata;
        s_cmd_wmask = m0_cmd_wmask;
        if (w_gnt == ID_M1) begin
            s_cmd_read  = m1_cmd_read;
            s_cmd_addr  = m1_cmd_addr;
            s_cmd_wdata = m1_cmd_wdata;
            s_cmd_wmask = m1_cmd_wmask;
        end else begin
            s_cmd_read  = m0_cmd_read;
            s_cmd_addr  = m0_cmd_addr;
            s_cmd_wdata = m0_cmd_wdata;
            s_cmd_wmask = m0_cmd_wmask;
        end
    end

    dtcm_arbiter_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (OUTS_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_cmd_hs),
        .i_din   (w_gnt),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head = mid_e'(w_fifo_dout);

    // Response routing; an orphan response (no owner recorded) is swallowed.
    always_comb begin
        s_rsp_ready = 1'b1;
        if (w_fifo_empty) begin
            s_rsp_ready = 1'b1;
        end else if (w_head == ID_M1) begin
            s_rsp_ready = m1_rsp_ready;
        end else begin
            s_rsp_ready = m0_rsp_ready;
        end
    end

    assign m0_rsp_valid = s_rsp_valid & ~w_fifo_empty & (w_head == ID_M0);
    assign m1_rsp_valid = s_rsp_valid & ~w_fifo_empty & (w_head == ID_M1);
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign w_pop        = s_rsp_valid & s_rsp_ready & ~w_fifo_empty;
    assign arb_err      = r_arb_err;

    // Round-robin history and stall lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_M1;
            r_lock       <= 1'b0;
            r_lock_id    <= ID_M0;
        end else begin
            if (w_cmd_hs) begin
                r_last_grant <= w_gnt;
                r_lock       <= 1'b0;
            end else if (s_cmd_valid) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_gnt;
            end else if (!w_gnt_valid) begin
                r_lock <= 1'b0;
            end else begin
                r_lock <= r_lock;
            end
        end
    end

    // Sticky error flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_err <= 1'b0;
        end else if (s_rsp_valid && w_fifo_empty) begin
            r_arb_err <= 1'b1;
        end else begin
            r_arb_err <= r_arb_err;
        end
    end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: queue-based masters, an in-order slave and a
// transaction-level model of grant, lock, outstanding owners and the error flag.
module tb_dtcm_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    logic m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready;
    logic m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready;
    logic [AW-1:0] m0_cmd_addr, m1_cmd_addr, s_cmd_addr;
    logic [DW-1:0] m0_cmd_wdata, m1_cmd_wdata, s_cmd_wdata;
    logic [MW-1:0] m0_cmd_wmask, m1_cmd_wmask, s_cmd_wmask;
    logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata, s_rsp_rdata;
    logic s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, arb_err;

    always #5 clk = ~clk;

    dtcm_arbiter #(.AW(AW), .DW(DW), .MW(MW), .OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .arb_err(arb_err)
    );

    cmd_t          mq0[$];
    cmd_t          mq1[$];
    logic [DW-1:0] sq[$];
    int            oq[$];
    logic [DW-1:0] mem [256];

    int  mdl_last;
    int  mdl_lock;
    bit  mdl_err;
    bit  sready, rsp_en, inj_err, r0rdy, r1rdy;
    int  total, bad;
    int  obs_gnt;
    bit  obs_svalid, obs_srdy, obs_rv0;
    logic [AW-1:0] obs_saddr;
    logic [DW-1:0] obs_r1data;
    int  n_rsp0, n_rsp1;

    // One clock of stimulus, reference-model prediction, comparison and model update.
    task automatic step();
        cmd_t c0, c1, gc;
        logic [63:0] rnd;
        bit v0, v1, exp_sv, hs, exp_rv0, exp_rv1, exp_srdy, pop;
        int g;
        logic [DW-1:0] rdat;
        v0  = (mq0.size() > 0);
        v1  = (mq1.size() > 0);
        rnd = {$urandom(), $urandom()};
        c0  = v0 ? mq0[0] : cmd_t'(rnd[$bits(cmd_t)-1:0]);
        rnd = {$urandom(), $urandom()};
        c1  = v1 ? mq1[0] : cmd_t'(rnd[$bits(cmd_t)-1:0]);
        m0_cmd_valid = v0; {m0_cmd_read, m0_cmd_addr, m0_cmd_wdata, m0_cmd_wmask} = c0;
        m1_cmd_valid = v1; {m1_cmd_read, m1_cmd_addr, m1_cmd_wdata, m1_cmd_wmask} = c1;
        s_cmd_ready  = sready;
        m0_rsp_ready = r0rdy;
        m1_rsp_ready = r1rdy;
        if (inj_err) begin
            s_rsp_valid = 1'b1; s_rsp_rdata = $urandom();
        end else if (rsp_en && sq.size() > 0) begin
            s_rsp_valid = 1'b1; s_rsp_rdata = sq[0];
        end else begin
            s_rsp_valid = 1'b0; s_rsp_rdata = $urandom();
        end
        @(negedge clk);
        if (mdl_lock >= 0)  g = mdl_lock;
        else if (v0 && v1)  g = 1 - mdl_last;
        else if (v1)        g = 1;
        else                g = 0;
        gc     = (g == 1) ? c1 : c0;
        exp_sv = ((g == 1) ? v1 : v0) && (oq.size() < DEPTH);
        hs     = exp_sv && sready;
        total++; if (s_cmd_valid !== exp_sv) begin bad++; $display("FAIL s_cmd_valid got=%b exp=%b t=%0t", s_cmd_valid, exp_sv, $time); end
        total++; if (m0_cmd_ready !== (hs && g == 0)) begin bad++; $display("FAIL m0_cmd_ready got=%b exp=%b t=%0t", m0_cmd_ready, (hs && g == 0), $time); end
        total++; if (m1_cmd_ready !== (hs && g == 1)) begin bad++; $display("FAIL m1_cmd_ready got=%b exp=%b t=%0t", m1_cmd_ready, (hs && g == 1), $time); end
        total++; if ({s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask} !== gc) begin bad++; $display("FAIL cmd_mux got=%h exp=%h t=%0t", {s_cmd_read, s_cmd_addr, s_cmd_wdata, s_cmd_wmask}, gc, $time); end
        total++; if (arb_err !== mdl_err) begin bad++; $display("FAIL arb_err got=%b exp=%b t=%0t", arb_err, mdl_err, $time); end
        exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_srdy = 1'b1;
        if (s_rsp_valid && oq.size() > 0) begin
            exp_rv0  = (oq[0] == 0);
            exp_rv1  = (oq[0] == 1);
            exp_srdy = (oq[0] == 1) ? r1rdy : r0rdy;
        end
        if (s_rsp_valid) begin
            total++; if (s_rsp_ready !== exp_srdy) begin bad++; $display("FAIL s_rsp_ready got=%b exp=%b t=%0t", s_rsp_ready, exp_srdy, $time); end
        end
        total++; if (m0_rsp_valid !== exp_rv0) begin bad++; $display("FAIL m0_rsp_valid got=%b exp=%b t=%0t", m0_rsp_valid, exp_rv0, $time); end
        total++; if (m1_rsp_valid !== exp_rv1) begin bad++; $display("FAIL m1_rsp_valid got=%b exp=%b t=%0t", m1_rsp_valid, exp_rv1, $time); end
        pop = s_rsp_valid && (oq.size() > 0) && exp_srdy;
        if (pop) begin
            rdat = (oq[0] == 1) ? m1_rsp_rdata : m0_rsp_rdata;
            total++; if (rdat !== sq[0]) begin bad++; $display("FAIL rsp_rdata got=%h exp=%h t=%0t", rdat, sq[0], $time); end
        end
        obs_gnt    = m0_cmd_ready ? 0 : (m1_cmd_ready ? 1 : -1);
        obs_svalid = s_cmd_valid;
        obs_srdy   = s_rsp_ready;
        obs_rv0    = m0_rsp_valid;
        obs_saddr  = s_cmd_addr;
        if (m0_rsp_valid && r0rdy) n_rsp0++;
        if (m1_rsp_valid && r1rdy) begin n_rsp1++; obs_r1data = m1_rsp_rdata; end
        if (s_rsp_valid && oq.size() == 0) mdl_err = 1'b1;
        if (pop) begin void'(oq.pop_front()); void'(sq.pop_front()); end
        if (hs) begin
            if (gc.rd) begin
                rdat = mem[gc.addr[7:0]];
            end else begin
                for (int b = 0; b < MW; b++)
                    if (gc.wmask[b]) mem[gc.addr[7:0]][8*b +: 8] = gc.wdata[8*b +: 8];
                rdat = {16'hA5A5, gc.addr};
            end
            oq.push_back(g);
            sq.push_back(rdat);
            if (g == 1) void'(mq1.pop_front()); else void'(mq0.pop_front());
            mdl_last = g;
            mdl_lock = -1;
        end else if (exp_sv) begin
            mdl_lock = g;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq0.delete(); mq1.delete(); sq.delete(); oq.delete();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0; s_rsp_valid = 1'b0;
        sready = 1'b0; rsp_en = 1'b0; inj_err = 1'b0; r0rdy = 1'b1; r1rdy = 1'b1;
        mdl_last = 1; mdl_lock = -1; mdl_err = 1'b0;
        #1;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input int m, input bit rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [MW-1:0] k);
        cmd_t c;
        c = '{rd: rd, addr: a, wdata: d, wmask: k};
        if (m == 1) mq1.push_back(c); else mq0.push_back(c);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0; s_cmd_ready = 1'b1; #1;
        total++; if (s_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_s_cmd_valid got=%b exp=0", s_cmd_valid); end
        total++; if ({m0_cmd_ready, m1_cmd_ready} !== 2'b00) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=00", {m0_cmd_ready, m1_cmd_ready}); end
        total++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {m0_rsp_valid, m1_rsp_valid}); end
        total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL reset_arb_err got=%b exp=0", arb_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_m0_stream();
        sready = 1'b1; rsp_en = 1'b1; r0rdy = 1'b1; r1rdy = 1'b1;
        n_rsp0 = 0; n_rsp1 = 0;
        for (int i = 0; i < 4; i++) push_cmd(0, 1'b1, 16'h0040 + 16'(i), 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 4) begin
                total++; if (obs_gnt !== 0) begin bad++; $display("FAIL stream_accept cyc=%0d got=%0d exp=0", i, obs_gnt); end
            end
            if (i >= 1 && i <= 4) begin
                total++; if (obs_rv0 !== 1'b1) begin bad++; $display("FAIL stream_rsp cyc=%0d got=%b exp=1", i, obs_rv0); end
            end
        end
        total++; if (n_rsp0 !== 4) begin bad++; $display("FAIL stream_m0_count got=%0d exp=4", n_rsp0); end
        total++; if (n_rsp1 !== 0) begin bad++; $display("FAIL stream_m1_count got=%0d exp=0", n_rsp1); end
    endtask

    task automatic test_round_robin();
        do_reset();
        sready = 1'b1; rsp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cmd(0, 1'b1, 16'h0080 + 16'(i), 32'h0, 4'h0);
            push_cmd(1, 1'b1, 16'h0090 + 16'(i), 32'h0, 4'h0);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (obs_gnt !== (i % 2)) begin bad++; $display("FAIL rr_grant cyc=%0d got=%0d exp=%0d", i, obs_gnt, i % 2); end
        end
        run(3);
    endtask

    task automatic test_lock();
        do_reset();
        sready = 1'b0; rsp_en = 1'b1;
        push_cmd(1, 1'b1, 16'h0020, 32'h0, 4'h0);
        step();
        push_cmd(0, 1'b0, 16'h0010, 32'h1111_2222, 4'hF);
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (obs_saddr !== 16'h0020) begin bad++; $display("FAIL lock_hold cyc=%0d got=%h exp=0020", i, obs_saddr); end
        end
        sready = 1'b1;
        step();
        total++; if (obs_gnt !== 1) begin bad++; $display("FAIL lock_release got=%0d exp=1", obs_gnt); end
        step();
        total++; if (obs_gnt !== 0) begin bad++; $display("FAIL lock_next got=%0d exp=0", obs_gnt); end
        run(3);
    endtask

    task automatic test_full();
        do_reset();
        sready = 1'b1; rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(0, 1'b1, 16'h00A0 + 16'(i), 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) rsp_en = 1'b1;
            step();
            total++; if (obs_svalid !== (i < 2 || i == 5)) begin bad++; $display("FAIL full_gate cyc=%0d got=%b exp=%b", i, obs_svalid, (i < 2 || i == 5)); end
        end
        run(3);
    endtask

    task automatic test_interleave();
        sready = 1'b1; rsp_en = 1'b1; r0rdy = 1'b1; r1rdy = 1'b1;
        mem[8'h20] = 32'hCAFE_0020;
        n_rsp0 = 0; n_rsp1 = 0;
        push_cmd(0, 1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        push_cmd(1, 1'b1, 16'h0020, 32'h0, 4'h0);
        push_cmd(0, 1'b0, 16'h0010, 32'h0000_1234, 4'h3);
        push_cmd(1, 1'b1, 16'h0020, 32'h0, 4'h0);
        run(8);
        total++; if (n_rsp0 !== 2) begin bad++; $display("FAIL inter_m0_count got=%0d exp=2", n_rsp0); end
        total++; if (n_rsp1 !== 2) begin bad++; $display("FAIL inter_m1_count got=%0d exp=2", n_rsp1); end
        total++; if (obs_r1data !== 32'hCAFE_0020) begin bad++; $display("FAIL inter_m1_data got=%h exp=cafe0020", obs_r1data); end
    endtask

    task automatic test_err();
        sready = 1'b1; rsp_en = 1'b1;
        run(2);
        inj_err = 1'b1;
        step();
        total++; if (obs_srdy !== 1'b1) begin bad++; $display("FAIL err_drop_ready got=%b exp=1", obs_srdy); end
        inj_err = 1'b0;
        push_cmd(0, 1'b1, 16'h0033, 32'h0, 4'h0);
        push_cmd(1, 1'b1, 16'h0034, 32'h0, 4'h0);
        run(4);
        total++; if (arb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", arb_err); end
        rsp_en = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(0, 1'b1, 16'h0050 + 16'(i), 32'h0, 4'h0);
        run(2);
        rst_n = 1'b0; #1;
        total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL err_reset got=%b exp=0", arb_err); end
        do_reset();
        total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL err_after_reset got=%b exp=0", arb_err); end
        push_cmd(0, 1'b1, 16'h0060, 32'h0, 4'h0);
        push_cmd(1, 1'b1, 16'h0061, 32'h0, 4'h0);
        sready = 1'b1; rsp_en = 1'b1;
        step();
        total++; if (obs_gnt !== 0) begin bad++; $display("FAIL reset_first_tie got=%0d exp=0", obs_gnt); end
        run(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (mq0.size() < 3 && $urandom_range(0, 9) < 3)
                push_cmd(0, 1'($urandom()), 16'($urandom()), $urandom(), 4'($urandom()));
            if (mq1.size() < 3 && $urandom_range(0, 9) < 3)
                push_cmd(1, 1'($urandom()), 16'($urandom()), $urandom(), 4'($urandom()));
            sready = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 9) < 7);
            r0rdy  = ($urandom_range(0, 4) != 0);
            r1rdy  = ($urandom_range(0, 4) != 0);
            step();
        end
        sready = 1'b1; rsp_en = 1'b1; r0rdy = 1'b1; r1rdy = 1'b1;
        run(20);
        total++; if (oq.size() !== 0) begin bad++; $display("FAIL random_drain got=%0d exp=0", oq.size()); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        n_rsp0 = 0; n_rsp1 = 0; obs_r1data = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        test_reset();
        test_m0_stream();
        test_round_robin();
        test_lock();
        test_full();
        test_interleave();
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
